// File: rtl/bch_delay_var.sv
// Run-time programmable delay line (1..pMaxDelay accepted samples) for BCH datapath alignment.
// Latency D accepted samples; advances only on i_en, holds all state while stalled.
module bch_delay_var #(
    parameter int pWidth    = 8,
    parameter int pMaxDelay = 16,
    parameter int pDlyWidth = 5,
    parameter int pDefDelay = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic [pWidth-1:0]    i_d,
    input  logic                 i_dly_ld,
    input  logic [pDlyWidth-1:0] i_dly,
    output logic [pWidth-1:0]    o_d,
    output logic                 o_vld,
    output logic [pDlyWidth-1:0] o_dly
);

    localparam int RING = pMaxDelay - 1;
    localparam int AW   = (RING > 1) ? $clog2(RING) : 1;
    localparam logic [pDlyWidth-1:0] MAX_D  = pDlyWidth'(pMaxDelay);
    localparam logic [pDlyWidth-1:0] DEF_D  = pDlyWidth'(pDefDelay);
    localparam logic [pDlyWidth-1:0] ONE    = pDlyWidth'(1);
    localparam logic [pDlyWidth:0]   RING_W = (pDlyWidth+1)'(RING);
    localparam logic [pDlyWidth:0]   MAX_W  = (pDlyWidth+1)'(pMaxDelay);
    localparam logic [AW-1:0]        WP_END = AW'(RING - 1);

    logic [pWidth-1:0]    ring [RING];
    logic [AW-1:0]        wp, wp_nxt, rd_idx;
    logic [pDlyWidth-1:0] dly, dly_nxt, cnt, cnt_base, cnt_nxt;
    logic [pDlyWidth:0]   rd_sum;
    logic                 vld_nxt;
    logic [pWidth-1:0]    d_nxt;

    always_comb begin
        dly_nxt = dly;
        if (i_dly_ld) begin
            if (i_dly == '0)
                dly_nxt = ONE;
            else if (i_dly > MAX_D)
                dly_nxt = MAX_D;
            else
                dly_nxt = i_dly;
        end

        // cnt never exceeds D, so stopping at equality is the saturating min
        cnt_base = i_dly_ld ? '0 : cnt;
        cnt_nxt  = cnt_base;
        if (i_en && (cnt_base != dly_nxt))
            cnt_nxt = cnt_base + ONE;
        vld_nxt = (cnt_nxt == dly_nxt);

        // read wp-(D-1) mod RING, kept non-negative by adding RING first
        rd_sum = (pDlyWidth+1)'(wp) + MAX_W - {1'b0, dly_nxt};
        rd_idx = (rd_sum >= RING_W) ? AW'(rd_sum - RING_W) : AW'(rd_sum);

        d_nxt = o_d;
        if (i_en) begin
            if (!vld_nxt)
                d_nxt = '0;
            else if (dly_nxt == ONE)
                d_nxt = i_d;
            else
                d_nxt = ring[rd_idx];
        end else if (i_dly_ld) begin
            d_nxt = '0;
        end

        wp_nxt = wp;
        if (i_en)
            wp_nxt = (wp == WP_END) ? '0 : wp + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dly   <= DEF_D;
            cnt   <= '0;
            wp    <= '0;
            o_d   <= '0;
            o_vld <= 1'b0;
        end else begin
            dly   <= dly_nxt;
            cnt   <= cnt_nxt;
            wp    <= wp_nxt;
            o_d   <= d_nxt;
            o_vld <= vld_nxt;
        end
    end

    // Ring storage has no reset; stale entries are masked by the fill counter
    always_ff @(posedge clk) begin
        if (i_en && !rst)
            ring[wp] <= i_d;
    end

    assign o_dly = dly;

endmodule
